// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_e;

    localparam int N_DEFAULT         = 4;
    localparam int BUSY_WAIT_DEFAULT = 4;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Client-side and UART-side signals of the arbiter, bundled as one interface.
interface uart_arb_if
    import uart_arb_pkg::*;
#(
    parameter int N = N_DEFAULT
);
    localparam int W = $clog2(N);

    logic [N-1:0]   req;
    logic [8*N-1:0] data;
    logic [N-1:0]   lock;
    logic [N-1:0]   ack;
    logic [7:0]     tx_data;
    logic           tx_wr;
    logic           tx_busy;
    logic [W-1:0]   grant_id;
    logic           err;

    // arbiter side
    modport slave (
        input  req, data, lock, tx_busy,
        output ack, tx_data, tx_wr, grant_id, err
    );

    // clients + UART side
    modport master (
        output req, data, lock, tx_busy,
        input  ack, tx_data, tx_wr, grant_id, err
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping N-1 -> 0.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 valid,
    output logic [$clog2(N)-1:0] idx
);
    localparam int W = $clog2(N);

    function automatic logic [W-1:0] wrap_add(input logic [W-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= N) begin
            s = s - N;
        end
        return W'(s);
    endfunction

    // Scan from the farthest offset down so the nearest hit to ptr wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[wrap_add(ptr, k)]) begin
                valid = 1'b1;
                idx   = wrap_add(ptr, k);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N byte clients.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  IDLE      | waiting for a request while the UART is not busy
//  ISSUE     | ack/tx_wr/tx_data visible for this one cycle
//  WAIT_BUSY | waiting for tx_busy to rise; timeout pulses err
//  WAIT_DONE | frame in flight, waiting for tx_busy to fall
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N         = N_DEFAULT,
    parameter int BUSY_WAIT = BUSY_WAIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    uart_arb_if.slave  bus
);
    localparam int W  = $clog2(N);
    localparam int CW = $clog2(BUSY_WAIT + 1);

    arb_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    ptr_q, ptr_d;
    logic [N-1:0]    ack_q, ack_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_wr_q, tx_wr_d;
    logic [W-1:0]    grant_id_q, grant_id_d;
    logic            err_q, err_d;

    logic            rr_valid;
    logic [W-1:0]    rr_idx;
    logic            lock_hit;
    logic [W-1:0]    win;

    rr_pick #(.N(N)) u_rr_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .valid (rr_valid),
        .idx   (rr_idx)
    );

    // A locked client that is still requesting keeps the grant ahead of round-robin.
    assign lock_hit = bus.lock[grant_id_q] & bus.req[grant_id_q];
    assign win      = lock_hit ? grant_id_q : rr_idx;

    // Next-state and next-output computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        ack_d      = '0;
        tx_data_d  = tx_data_q;
        tx_wr_d    = 1'b0;
        grant_id_d = grant_id_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (rr_valid && !bus.tx_busy) begin
                    ack_d[win] = 1'b1;
                    tx_data_d  = bus.data[8*int'(win) +: 8];
                    tx_wr_d    = 1'b1;
                    grant_id_d = win;
                    if (!lock_hit) begin
                        ptr_d = (int'(win) == N - 1) ? '0 : win + W'(1);
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                cnt_d = cnt_q + CW'(1);
                // busy takes priority over a simultaneous timeout
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_d == CW'(BUSY_WAIT)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter, pointer and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            ack_q      <= '0;
            tx_data_q  <= '0;
            tx_wr_q    <= 1'b0;
            grant_id_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            ack_q      <= ack_d;
            tx_data_q  <= tx_data_d;
            tx_wr_q    <= tx_wr_d;
            grant_id_q <= grant_id_d;
            err_q      <= err_d;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_wr    = tx_wr_q;
    assign bus.grant_id = grant_id_q;
    assign bus.err      = err_q;

endmodule
